// File: rtl/wdt_pkg.sv
// Shared types, defaults and sizing helper for the multi-channel watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } wdt_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_TIMEOUT     = 1_000_000;
  localparam int DEF_WARN_MARGIN = 16;

  // Channel index width; a single channel still needs one bit of index.
  function automatic int calc_ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_channel_watchdog_if.sv
// Control/status bundle between a supervisor and the watchdog block.
interface multi_channel_watchdog_if
  import wdt_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = calc_ch_w(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] kick;
  logic [NUM_CH-1:0] clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_val;
  logic [NUM_CH-1:0] warn;
  logic [NUM_CH-1:0] expired;
  logic              any_expired;
  logic [CH_W-1:0]   first_ch;
  logic              stop_req;

  modport master (
    output en, kick, clr, cfg_we, cfg_ch, cfg_val,
    input  warn, expired, any_expired, first_ch, stop_req
  );

  modport slave (
    input  en, kick, clr, cfg_we, cfg_ch, cfg_val,
    output warn, expired, any_expired, first_ch, stop_req
  );

endinterface

// File: rtl/wdt_channel.sv
// One watchdog channel: limit register, down-counter and arm/expire FSM.
//
// state   | meaning
// IDLE    | counter held, waiting for en
// ARMED   | counting down from limit, kick reloads
// EXPIRED | sticky timeout, only clr leaves
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int WARN_MARGIN = DEF_WARN_MARGIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_val,
  output logic             warn,
  output logic             expired,
  output logic             expiring
);

  wdt_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             limit_zero;

  assign limit_zero = (limit == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; in ARMED, disable beats kick beats terminal count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = ARMED;
      ARMED: begin
        if (!en)                                     state_nxt = IDLE;
        else if (!kick && !limit_zero && cnt == CNT_W'(1)) state_nxt = EXPIRED;
      end
      EXPIRED: if (clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; expiring lets the top register its summary in step with expired.
  always_comb begin
    warn     = (state == ARMED) && !limit_zero && (cnt <= CNT_W'(WARN_MARGIN));
    expired  = (state == EXPIRED);
    expiring = (state_nxt == EXPIRED);
  end

  // Limit register and down-counter. A limit of zero parks the counter, and a
  // count of zero (loaded while limit was zero) waits for a kick to reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit <= CNT_W'(TIMEOUT);
      cnt   <= '0;
    end else begin
      if (cfg_we) limit <= cfg_val;
      if (state == IDLE && en) begin
        cnt <= limit;
      end else if (state == ARMED && en) begin
        if (kick)                                      cnt <= limit;
        else if (!limit_zero && cnt > CNT_W'(1))       cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_channel_watchdog.sv
// Multi-channel watchdog top: channel array, config decode, first-expiry capture.
module multi_channel_watchdog
  import wdt_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int WARN_MARGIN = DEF_WARN_MARGIN
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_channel_watchdog_if.slave bus
);

  localparam int CH_W = calc_ch_w(NUM_CH);

  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] warn_v;
  logic [NUM_CH-1:0] exp_v;
  logic [NUM_CH-1:0] exp_nxt;
  logic              any_nxt;
  logic [CH_W-1:0]   first_nxt;
  logic              any_q;
  logic [CH_W-1:0]   first_q;
  logic              stop_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range cfg_ch values match no channel and are dropped.
    assign cfg_hit[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    wdt_channel #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .WARN_MARGIN (WARN_MARGIN)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en[i]),
      .kick     (bus.kick[i]),
      .clr      (bus.clr[i]),
      .cfg_we   (cfg_hit[i]),
      .cfg_val  (bus.cfg_val),
      .warn     (warn_v[i]),
      .expired  (exp_v[i]),
      .expiring (exp_nxt[i])
    );
  end

  assign any_nxt = |exp_nxt;

  // Lowest-index channel among those expired after this edge.
  always_comb begin
    first_nxt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (exp_nxt[i]) first_nxt = CH_W'(i);
    end
  end

  // Summary flags, built from next-state so they line up with expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_q   <= 1'b0;
      first_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      any_q  <= any_nxt;
      stop_q <= any_nxt && !any_q;
      if (any_nxt && !any_q) first_q <= first_nxt;
    end
  end

  assign bus.warn        = warn_v;
  assign bus.expired     = exp_v;
  assign bus.any_expired = any_q;
  assign bus.first_ch    = first_q;
  assign bus.stop_req    = stop_q;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog (NUM_CH=4, TIMEOUT=8, WARN_MARGIN=2).
module tb_multi_channel_watchdog;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic seen;

  multi_channel_watchdog_if #(.NUM_CH(4), .CNT_W(20)) wd_if ();

  multi_channel_watchdog #(
    .NUM_CH      (4),
    .CNT_W       (20),
    .TIMEOUT     (8),
    .WARN_MARGIN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (wd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    wd_if.en       = '0;
    wd_if.kick     = '0;
    wd_if.clr      = '0;
    wd_if.cfg_we   = 1'b0;
    wd_if.cfg_ch   = '0;
    wd_if.cfg_val  = '0;

    step(2);
    chk("rst_warn",  32'(wd_if.warn), 0);
    chk("rst_exp",   32'(wd_if.expired), 0);
    chk("rst_any",   32'(wd_if.any_expired), 0);
    chk("rst_first", 32'(wd_if.first_ch), 0);
    chk("rst_stop",  32'(wd_if.stop_req), 0);
    rst = 1'b0;

    // Basic expiry on ch0: warn 6 cycles, expiry 8 cycles after arming.
    wd_if.en[0] = 1'b1;
    step(1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("t1_warn", 32'(wd_if.warn[0]), 32'(k >= 6 && k < 8));
      chk("t1_exp",  32'(wd_if.expired[0]), 32'(k >= 8));
    end
    chk("t1_any",   32'(wd_if.any_expired), 1);
    chk("t1_stop",  32'(wd_if.stop_req), 1);
    chk("t1_first", 32'(wd_if.first_ch), 0);
    step(1);
    chk("t1_stop_pulse", 32'(wd_if.stop_req), 0);
    chk("t1_sticky",     32'(wd_if.expired[0]), 1);

    // Clear with en held, re-arm on the following edge, expire again.
    wd_if.clr[0] = 1'b1;
    step(1);
    wd_if.clr[0] = 1'b0;
    chk("t5_clr_exp", 32'(wd_if.expired[0]), 0);
    chk("t5_clr_any", 32'(wd_if.any_expired), 0);
    step(1);
    step(7);
    chk("t5_pre_exp",  32'(wd_if.expired[0]), 0);
    chk("t5_pre_stop", 32'(wd_if.stop_req), 0);
    step(1);
    chk("t5_exp",   32'(wd_if.expired[0]), 1);
    chk("t5_stop",  32'(wd_if.stop_req), 1);
    chk("t5_first", 32'(wd_if.first_ch), 0);
    wd_if.en[0]  = 1'b0;
    wd_if.clr[0] = 1'b1;
    step(1);
    wd_if.clr[0] = 1'b0;
    chk("t5_done_any", 32'(wd_if.any_expired), 0);

    // Kick refresh on ch1 every 7 cycles.
    wd_if.en[1] = 1'b1;
    step(1);
    seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      wd_if.kick[1] = (c % 7 == 0);
      step(1);
      if (wd_if.expired[1]) seen = 1'b1;
    end
    wd_if.kick[1] = 1'b0;
    chk("t2_no_exp", 32'(seen), 0);
    // Kick on exactly the 8th cycle after a reload still saves the channel.
    wd_if.kick[1] = 1'b1;
    step(1);
    wd_if.kick[1] = 1'b0;
    step(7);
    chk("t2_cnt1_exp", 32'(wd_if.expired[1]), 0);
    wd_if.kick[1] = 1'b1;
    step(1);
    wd_if.kick[1] = 1'b0;
    chk("t2_kick8_exp", 32'(wd_if.expired[1]), 0);
    step(7);
    chk("t2_pre_exp", 32'(wd_if.expired[1]), 0);
    step(1);
    chk("t2_exp",   32'(wd_if.expired[1]), 1);
    chk("t2_first", 32'(wd_if.first_ch), 1);
    chk("t2_stop",  32'(wd_if.stop_req), 1);
    wd_if.en[1]  = 1'b0;
    wd_if.clr[1] = 1'b1;
    step(1);
    wd_if.clr[1] = 1'b0;

    // Simultaneous expiry of ch1 and ch3 with limit 5.
    wd_if.cfg_we  = 1'b1;
    wd_if.cfg_ch  = 2'd1;
    wd_if.cfg_val = 20'd5;
    step(1);
    wd_if.cfg_ch  = 2'd3;
    step(1);
    wd_if.cfg_we  = 1'b0;
    wd_if.en      = 4'b1010;
    step(1);
    step(4);
    chk("t3_pre_exp", 32'(wd_if.expired), 0);
    step(1);
    chk("t3_exp",   32'(wd_if.expired), 32'h0000_000a);
    chk("t3_first", 32'(wd_if.first_ch), 1);
    chk("t3_stop",  32'(wd_if.stop_req), 1);
    step(1);
    chk("t3_stop_pulse", 32'(wd_if.stop_req), 0);
    wd_if.en  = 4'b0000;
    wd_if.clr = 4'b1010;
    step(1);
    wd_if.clr = 4'b0000;
    chk("t3_clr_any", 32'(wd_if.any_expired), 0);

    // Limit 0 on ch2 never warns or expires; then limit 4 takes effect on kick.
    wd_if.cfg_we  = 1'b1;
    wd_if.cfg_ch  = 2'd2;
    wd_if.cfg_val = 20'd0;
    step(1);
    wd_if.cfg_we  = 1'b0;
    wd_if.en[2]   = 1'b1;
    step(1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (wd_if.warn[2] || wd_if.expired[2]) seen = 1'b1;
    end
    chk("t4_zero_quiet", 32'(seen), 0);
    wd_if.cfg_we  = 1'b1;
    wd_if.cfg_val = 20'd4;
    step(1);
    wd_if.cfg_we  = 1'b0;
    wd_if.kick[2] = 1'b1;
    step(1);
    wd_if.kick[2] = 1'b0;
    chk("t4_warn_lo", 32'(wd_if.warn[2]), 0);
    step(2);
    chk("t4_warn_hi", 32'(wd_if.warn[2]), 1);
    chk("t4_exp_2",   32'(wd_if.expired[2]), 0);
    step(1);
    chk("t4_exp_3",   32'(wd_if.expired[2]), 0);
    step(1);
    chk("t4_exp_4",   32'(wd_if.expired[2]), 1);
    chk("t4_first",   32'(wd_if.first_ch), 2);
    chk("t4_stop",    32'(wd_if.stop_req), 1);

    // Reset with ch0 armed at cnt=3 and ch2 expired; cfg write during rst is dropped.
    wd_if.en[0] = 1'b1;
    step(1);
    step(5);
    chk("t6_pre_exp", 32'(wd_if.expired), 32'h0000_0004);
    rst           = 1'b1;
    wd_if.cfg_we  = 1'b1;
    wd_if.cfg_ch  = 2'd0;
    wd_if.cfg_val = 20'd3;
    step(1);
    rst           = 1'b0;
    wd_if.cfg_we  = 1'b0;
    wd_if.en      = 4'b0000;
    chk("t6_warn",  32'(wd_if.warn), 0);
    chk("t6_exp",   32'(wd_if.expired), 0);
    chk("t6_any",   32'(wd_if.any_expired), 0);
    chk("t6_first", 32'(wd_if.first_ch), 0);
    chk("t6_stop",  32'(wd_if.stop_req), 0);
    step(20);
    chk("t6_idle_exp", 32'(wd_if.expired), 0);
    // Every limit should be back to 8.
    wd_if.en = 4'b0111;
    step(1);
    step(7);
    chk("t6_lim_pre",  32'(wd_if.expired), 0);
    chk("t6_lim_warn", 32'(wd_if.warn), 32'h0000_0007);
    step(1);
    chk("t6_lim_exp",   32'(wd_if.expired), 32'h0000_0007);
    chk("t6_lim_first", 32'(wd_if.first_ch), 0);
    chk("t6_lim_stop",  32'(wd_if.stop_req), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_watchdog.md
# multi_channel_watchdog

Parametrised cycle-count watchdog for simulation environments and on-chip supervision. It generalises the single fixed bench timeout into NUM_CH independent channels. Each channel has a runtime-programmable limit, a kick/refresh input, an early-warning flag and a sticky expiry. A global stop request fires on the first expiry, and the offending channel is recorded.

## Interface
- NUM_CH, 4: number of independent watchdog channels (1..32)
- CNT_W, 20: counter / limit width in bits
- TIMEOUT, 1_000_000: reset value of every channel limit; must fit CNT_W
- WARN_MARGIN, 16: warn asserts when remaining count <= WARN_MARGIN
- CH_W, derived: max(1, clog2(NUM_CH))
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel arm enable (level)
- kick  in  NUM_CH  per-channel refresh (pulse, sampled each edge)
- clr  in  NUM_CH  per-channel clear of sticky expiry
- cfg_we  in  1  limit write strobe
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_val  in  CNT_W  new limit; 0 = channel never expires
- warn  out  NUM_CH  channel armed and remaining <= WARN_MARGIN
- expired  out  NUM_CH  sticky per-channel expiry
- any_expired  out  1  OR of expired
- first_ch  out  CH_W  channel that caused the first expiry
- stop_req  out  1  one-cycle pulse on the cycle any_expired rises

## Operation
- Per-channel FSM:
  - IDLE: counter held. en=1 leads to ARMED, with cnt loaded from limit.
  - ARMED: counter is counting down.
  - EXPIRED: sticky.
- ARMED, per edge, in priority order:
  - en=0 leads to IDLE.
  - kick=1 reloads cnt from limit.
  - cnt==1 with no kick leads to EXPIRED.
  - Otherwise cnt decrements.
- Kick on the same edge as would-be expiry: kick wins, no expiry.
- limit==0: the channel arms but never decrements or expires; warn stays 0.
- EXPIRED: clr=1 leads to IDLE. en and kick are ignored. clr in IDLE/ARMED is a no-op.
- cfg_we writes limit[cfg_ch] at the edge. A currently armed channel uses the new value on its next load/reload. cfg_ch >= NUM_CH is ignored.
- warn is combinational from state/cnt: state==ARMED && limit!=0 && cnt<=WARN_MARGIN.
- first_ch latches on the edge where any_expired goes 0->1. On simultaneous expiries the lowest index wins. It holds until all channels are cleared, then is updated on the next rise.
- stop_req is 1 for exactly the cycle after that edge, registered alongside first_ch.
- Reset values: every limit=TIMEOUT, state=IDLE, cnt=0, warn=0, expired=0, any_expired=0, first_ch=0, stop_req=0.
- rst mid-count or mid-expiry returns everything to reset values on that edge. cfg_we is ignored while rst=1.

## Timing
- Arm: en sampled 1 at edge E0 makes state ARMED with cnt=L after E0.
- With no kicks, expired rises after edge E0+L−1+1 = E0+L, i.e. L cycles after arming.
- warn first rises after edge E0+(L−WARN_MARGIN) when L>WARN_MARGIN. If L<=WARN_MARGIN it rises immediately after E0.
- Kick at edge Ek gives cnt=L after Ek, so expiry moves to Ek+L.
- any_expired, first_ch and stop_req are registered, visible in the same cycle as expired (no extra latency).
- clr at edge Ec: expired falls after Ec. any_expired falls after Ec if no other channel is expired. Re-arm requires en=1 at a later edge.

## Structure
- Package wdt_pkg holds:
  - state enum {IDLE, ARMED, EXPIRED}
  - CH_W computation function
  - the default constants
- Sub-module wdt_channel holds one channel: FSM, limit register, down-counter, warn/expired.
- Top level holds:
  - NUM_CH generate instances
  - cfg decode
  - priority encoder for first_ch
  - rise detector for stop_req

## Test plan
- Basic expiry (TIMEOUT=8, WARN_MARGIN=2): raise en on ch0, never kick. Required: warn[0] rises 6 cycles after arming, expired[0]/any_expired rise 8 cycles after arming, stop_req is a 1-cycle pulse, first_ch=0.
- Kick refresh: L=8, kick ch1 every 7 cycles for 100 cycles. Required: expired[1] never asserts. Kick on exactly the 8th cycle also prevents expiry.
- Simultaneous expiry: arm ch3 and ch1 on the same edge with L=5. Required: both expired rise together, first_ch=1, a single stop_req pulse.
- Config and disable: write cfg_val=0 to ch2, arm it, run 50 cycles with no expiry and no warn. Write 4 while armed, then kick. Required: expiry 4 cycles after the kick.
- Clear and re-arm: after ch0 expires, pulse clr[0] with en still 1. Required: expired[0] falls next edge. The channel re-arms the following edge, and a second expiry yields a fresh stop_req and first_ch=0.
- Reset mid-operation: assert rst for 1 cycle with ch0 armed at cnt=3 and ch2 expired. Required: all outputs 0, limits back to TIMEOUT, no expiry while en stays low.
